comm_slave: RTL and testbench
=============================

// Module: comm_slave
// PURPOSE
//  Airframe-side end of the 3-byte command link: receives cmd, data[15:8], data[7:0] (in that
//  order) over UART, presents a complete {cmd,data} packet to the command processor with a
//  sticky ready flag, and returns a single 8-bit response byte on request.
//  Sits between the RX/TX pins and cmd_cfg; instantiates the team UART.
// PARAMETERS
//  BYTE_TO   1_000_000  inter-byte timeout in clk cycles; a partial packet older than this is dropped
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  RX           in   1   serial in from the ground station
//  TX           out  1   serial out to the ground station
//  cmd          out  8   opcode of last complete packet
//  data         out  16  payload of last complete packet, {high,low}
//  cmd_rdy      out  1   sticky: complete packet available on cmd/data
//  clr_cmd_rdy  in   1   consumer knocks down cmd_rdy
//  resp         in   8   response byte to send
//  send_resp    in   1   1-cycle pulse: transmit resp
//  resp_sent    out  1   high once response fully shifted out; low while sending
// BEHAVIOUR
//  Interface: one clock, clk; reset rst_n asynchronous, active-low.
//  Reset: cmd=8'h00, data=16'h0000, cmd_rdy=0, resp_sent=0, TX=1 (UART idle), state=WAIT_CMD, timer=0.
//  RX FSM (rx_state_t): WAIT_CMD -> WAIT_HIGH -> WAIT_LOW -> WAIT_CMD.
//   - Each state advances on UART rx_rdy; the byte is captured into a holding register and
//     clr_rx_rdy pulses in that same cycle (one pulse per byte, never two).
//   - WAIT_CMD: byte -> cmd_hold; WAIT_HIGH: byte -> high_hold; WAIT_LOW: byte completes packet.
//   - Completion: cycle after low byte rx_rdy, cmd<=cmd_hold, data<={high_hold,byte}, cmd_rdy<=1.
//     cmd/data change ONLY on completion; stable between packets and across partial packets.
//  cmd_rdy: set on completion; cleared by clr_cmd_rdy or by acceptance of the next cmd byte.
//   - Set and clr_cmd_rdy in same cycle: set wins (new packet never lost).
//   - Packet completing while cmd_rdy still 1: overwrite cmd/data, cmd_rdy stays 1 (no overrun flag).
//  Timeout: timer resets on every accepted byte, counts only in WAIT_HIGH/WAIT_LOW; reaching
//   BYTE_TO-1 forces WAIT_CMD, discards holding regs, cmd/data/cmd_rdy untouched. A byte
//   arriving in the timeout cycle is treated as a new cmd byte. Width $clog2(BYTE_TO).
//  TX path: send_resp while idle -> UART trmt same cycle, tx_data=resp, resp_sent<=0 next cycle,
//   busy<=1. On UART tx_done while busy: busy<=0, resp_sent<=1 (held until next send_resp).
//   send_resp while busy is ignored (no queueing, resp_sent unaffected).
//  RX and TX paths fully independent; full-duplex traffic must not interact.
//  rst_n mid-packet or mid-response: all state to reset values immediately; partial packet lost,
//   TX line returns to 1 (frame truncated).
// STRUCTURE
//  comm_pkg: rx_state_t enum {WAIT_CMD,WAIT_HIGH,WAIT_LOW}; localparam PKT_BYTES=3; shared
//   with the ground-station command master so byte order is defined once.
//  Sub-module: UART (existing RX+TX pair) instantiated once; everything else in comm_slave.
//  Flops: FSM state, cmd_hold, high_hold, cmd, data, cmd_rdy, timer, busy, resp_sent.
// TESTING
//  Drive bytes 8'h05,8'hA5,8'h3C through a UART TX model -> cmd=8'h05, data=16'hA53C, cmd_rdy=1
//   exactly 1 cycle after 3rd rx_rdy; exactly 3 clr_rx_rdy pulses.
//  Send 8'h02,8'h12 then stall > BYTE_TO (use BYTE_TO=1000) then 8'h06,8'h00,8'h01 -> cmd=8'h06,
//   data=16'h0001; cmd/data never show 8'h02/8'h12.
//  Packet complete, assert clr_cmd_rdy in completion cycle -> cmd_rdy=1; pulse next cycle -> 0.
//  send_resp with resp=8'hA5 -> TX line decodes 8'hA5; resp_sent 0 during frame, 1 after;
//   second send_resp mid-frame ignored (only one byte on TX).
//  Full duplex: send resp=8'h5A while receiving 8'h04,8'hFF,8'hFF -> both intact, data=16'hFFFF.
//  Assert rst_n low after 2nd byte and mid-TX -> all outputs reset values, TX=1; next full
//   packet 8'h01,8'h00,8'h10 received correctly.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared definitions for the 3-byte command link (cmd, data high, data low).
// Used by both the airframe slave and the ground-station master.
package comm_pkg;

    typedef enum logic [1:0] {
        WAIT_CMD,
        WAIT_HIGH,
        WAIT_LOW
    } rx_state_t;

    localparam int PKT_BYTES = 3;

    typedef logic [PKT_BYTES*8-1:0] pkt_t;

endpackage

// File: rtl/comm_uart.sv
// Team UART: 8N1 receiver and transmitter sharing one baud divisor.
// rx_rdy_o holds until clr_rx_rdy_i; tx_done_o pulses once per frame.
module comm_uart #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       tx_o,
    output logic [7:0] rx_data_o,
    output logic       rx_rdy_o,
    input  logic       clr_rx_rdy_i,
    input  logic       trmt_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_done_o
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] FULL = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF = BW'(BAUD_DIV / 2 - 1);

    logic          rx_s1_q;
    logic          rx_s2_q;
    logic          rx_busy_q;
    logic [BW-1:0] rx_cnt_q;
    logic [3:0]    rx_bits_q;
    logic [8:0]    rx_sh_q;
    logic [7:0]    rx_data_q;
    logic          rx_rdy_q;

    logic          tx_busy_q;
    logic [BW-1:0] tx_cnt_q;
    logic [3:0]    tx_bits_q;
    logic [9:0]    tx_sh_q;
    logic          tx_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_busy_q <= 1'b0;
            rx_cnt_q  <= '0;
            rx_bits_q <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            rx_rdy_q  <= 1'b0;
        end else begin
            rx_s1_q <= rx_i;
            rx_s2_q <= rx_s1_q;
            if (clr_rx_rdy_i) begin
                rx_rdy_q <= 1'b0;
            end
            if (!rx_busy_q) begin
                if (!rx_s2_q) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= HALF;
                    rx_bits_q <= '0;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - BW'(1);
            end else begin
                rx_cnt_q  <= FULL;
                rx_bits_q <= rx_bits_q + 4'd1;
                rx_sh_q   <= {rx_s2_q, rx_sh_q[8:1]};
                // line back high at mid start bit: glitch, not a frame
                if (rx_bits_q == 4'd0 && rx_s2_q) begin
                    rx_busy_q <= 1'b0;
                end
                if (rx_bits_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    rx_rdy_q  <= 1'b1;
                    rx_data_q <= rx_sh_q[8:1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_q <= 1'b0;
            tx_cnt_q  <= '0;
            tx_bits_q <= '0;
            tx_sh_q   <= '1;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            if (!tx_busy_q) begin
                if (trmt_i) begin
                    tx_busy_q <= 1'b1;
                    tx_sh_q   <= {1'b1, tx_data_i, 1'b0};
                    tx_cnt_q  <= FULL;
                    tx_bits_q <= '0;
                end
            end else if (tx_cnt_q != '0) begin
                tx_cnt_q <= tx_cnt_q - BW'(1);
            end else begin
                tx_cnt_q  <= FULL;
                tx_sh_q   <= {1'b1, tx_sh_q[9:1]};
                tx_bits_q <= tx_bits_q + 4'd1;
                if (tx_bits_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_done_q <= 1'b1;
                end
            end
        end
    end

    assign tx_o      = tx_busy_q ? tx_sh_q[0] : 1'b1;
    assign rx_data_o = rx_data_q;
    assign rx_rdy_o  = rx_rdy_q;
    assign tx_done_o = tx_done_q;

endmodule

// File: rtl/comm_slave.sv
// Airframe end of the 3-byte command link: assembles {cmd,high,low}
// into a sticky packet and returns one response byte on request.
module comm_slave
    import comm_pkg::*;
#(
    parameter int BYTE_TO  = 1_000_000,
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam int TW = $clog2(BYTE_TO);
    localparam logic [TW-1:0] TO_MAX = TW'(BYTE_TO - 1);

    rx_state_t   state_q, state_d;
    logic [7:0]  cmd_hold_q, cmd_hold_d;
    logic [7:0]  high_hold_q, high_hold_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic        cmd_rdy_q, rdy_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        busy_q, busy_d;
    logic        resp_sent_q, sent_d;

    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [7:0]  rx_data;
    logic        trmt;
    logic        tx_done;
    logic        timeout;
    logic        start_pkt;
    pkt_t        pkt;

    comm_uart #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (RX),
        .tx_o        (TX),
        .rx_data_o   (rx_data),
        .rx_rdy_o    (rx_rdy),
        .clr_rx_rdy_i(clr_rx_rdy),
        .trmt_i      (trmt),
        .tx_data_i   (resp),
        .tx_done_o   (tx_done)
    );

    assign timeout   = (state_q != WAIT_CMD) && (timer_q == TO_MAX);
    assign start_pkt = timeout || (state_q == WAIT_CMD);
    assign pkt       = {cmd_hold_q, high_hold_q, rx_data};

    always_comb begin
        state_d     = state_q;
        cmd_hold_d  = cmd_hold_q;
        high_hold_d = high_hold_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        rdy_d       = cmd_rdy_q;
        timer_d     = timer_q;
        clr_rx_rdy  = 1'b0;
        if (clr_cmd_rdy) begin
            rdy_d = 1'b0;
        end
        if (state_q != WAIT_CMD) begin
            timer_d = timer_q + TW'(1);
        end
        if (timeout) begin
            state_d     = WAIT_CMD;
            cmd_hold_d  = '0;
            high_hold_d = '0;
            timer_d     = '0;
        end
        // a byte in the timeout cycle opens a fresh packet
        if (rx_rdy) begin
            clr_rx_rdy = 1'b1;
            timer_d    = '0;
            unique case (1'b1)
                start_pkt: begin
                    cmd_hold_d = rx_data;
                    rdy_d      = 1'b0;
                    state_d    = WAIT_HIGH;
                end
                (state_q == WAIT_HIGH): begin
                    high_hold_d = rx_data;
                    state_d     = WAIT_LOW;
                end
                default: begin
                    cmd_d   = pkt[PKT_BYTES*8-1 -: 8];
                    data_d  = pkt[15:0];
                    rdy_d   = 1'b1;
                    state_d = WAIT_CMD;
                end
            endcase
        end
    end

    assign trmt = send_resp && !busy_q;

    always_comb begin
        busy_d = busy_q;
        sent_d = resp_sent_q;
        if (trmt) begin
            busy_d = 1'b1;
            sent_d = 1'b0;
        end else if (busy_q && tx_done) begin
            busy_d = 1'b0;
            sent_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_CMD;
            cmd_hold_q  <= '0;
            high_hold_q <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            cmd_rdy_q   <= 1'b0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_hold_q  <= cmd_hold_d;
            high_hold_q <= high_hold_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            cmd_rdy_q   <= rdy_d;
            timer_q     <= timer_d;
            busy_q      <= busy_d;
            resp_sent_q <= sent_d;
        end
    end

    assign cmd       = cmd_q;
    assign data      = data_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_comm_slave.sv
// Bench for comm_slave: UART line models on RX/TX and a packet-level
// reference model compared against cmd/data/cmd_rdy every quiet cycle.
module tb_comm_slave;

    localparam int BAUD    = 32;
    localparam int BYTE_TO = 1000;
    localparam int FRAME   = 10 * BAUD;
    localparam int LONG    = BYTE_TO + 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;

    comm_slave #(
        .BYTE_TO (BYTE_TO),
        .BAUD_DIV(BAUD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .data       (data),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp       (resp),
        .send_resp  (send_resp),
        .resp_sent  (resp_sent)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  exp_cmd = 8'h00;
    logic [15:0] exp_data = 16'h0000;
    logic        exp_rdy = 1'b0;
    logic [7:0]  partial[$];
    bit          rx_busy = 1'b0;
    bit          chk_on = 1'b0;

    logic [7:0]  tx_exp[$];
    logic [7:0]  tx_got[$];
    int          rst_cnt = 0;
    int          clr_cnt = 0;
    logic        prev_rx_rdy = 1'b0;
    logic        prev_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // packet-level model: bytes in order, stale partials dropped
    task automatic model_byte(input logic [7:0] b, input bit stale);
        if (stale) partial.delete();
        partial.push_back(b);
        if (partial.size() == 1) exp_rdy = 1'b0;
        if (partial.size() == 3) begin
            exp_cmd  = partial[0];
            exp_data = {partial[1], partial[2]};
            exp_rdy  = 1'b1;
            partial.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        repeat (gap) @(posedge clk);
        rx_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1 RX = fr[i];
            repeat (BAUD) @(posedge clk);
        end
        model_byte(b, gap > BYTE_TO);
        repeat (2) @(posedge clk);
        rx_busy = 1'b0;
    endtask

    task automatic clr_pulse();
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b0;
        exp_rdy = 1'b0;
    endtask

    task automatic do_resp(input logic [7:0] b, input bit dbl);
        bit hi_seen;
        int waited;
        @(posedge clk);
        #1 resp = b;
        send_resp = 1'b1;
        @(posedge clk);
        #1 send_resp = 1'b0;
        resp = ~b;
        tx_exp.push_back(b);
        hi_seen = 1'b0;
        for (int i = 0; i < FRAME - 4; i++) begin
            send_resp = dbl && (i == 3 * BAUD);
            if (resp_sent) hi_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        send_resp = 1'b0;
        chk("resp_sent_low", {31'd0, hi_seen}, 0);
        waited = 0;
        while (!resp_sent && waited < 4 * BAUD) begin
            @(posedge clk);
            #1 waited++;
        end
        chk("resp_sent_high", {31'd0, resp_sent}, 1);
    endtask

    task automatic tx_drain();
        while (tx_exp.size() > 0) begin
            logic [7:0] e;
            e = tx_exp.pop_front();
            if (tx_got.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_missing: got none want %h", e);
            end else begin
                chk("tx_byte", {24'd0, tx_got.pop_front()}, {24'd0, e});
            end
        end
        chk("tx_extra", tx_got.size(), 0);
    endtask

    always @(negedge clk) begin
        if (chk_on && rst_n && !rx_busy) begin
            n_cmp++;
            if ({cmd, data, cmd_rdy} !== {exp_cmd, exp_data, exp_rdy}) begin
                n_bad++;
                if (n_bad < 20)
                    $display("FAIL model: got cmd=%h data=%h rdy=%b want cmd=%h data=%h rdy=%b",
                             cmd, data, cmd_rdy, exp_cmd, exp_data, exp_rdy);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (dut.clr_rx_rdy) clr_cnt++;
            if (cmd_rdy && !prev_rdy)
                chk("rdy_latency", {31'd0, prev_rx_rdy}, 1);
        end
        prev_rx_rdy = dut.rx_rdy;
        prev_rdy    = cmd_rdy;
    end

    initial begin
        logic [7:0] b;
        int rc;
        bit ok;
        forever begin
            @(negedge TX);
            if (rst_n === 1'b1) begin
                rc = rst_cnt;
                repeat (BAUD / 2) @(negedge clk);
                ok = (TX == 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = TX;
                end
                repeat (BAUD) @(negedge clk);
                ok = ok && (TX == 1'b1);
                if (rc == rst_cnt) begin
                    chk("tx_frame", {31'd0, ok}, 1);
                    tx_got.push_back(b);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        bit seen;
        #23;
        chk("rst_cmd", {24'd0, cmd}, 0);
        chk("rst_data", {16'd0, data}, 0);
        chk("rst_rdy", {31'd0, cmd_rdy}, 0);
        chk("rst_resp_sent", {31'd0, resp_sent}, 0);
        chk("rst_tx", {31'd0, TX}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;

        c0 = clr_cnt;
        send_byte(8'h05, 5);
        send_byte(8'hA5, 20);
        send_byte(8'h3C, 20);
        chk("clr_rx_pulses", clr_cnt - c0, 3);
        chk("pkt1_cmd", {24'd0, cmd}, 32'h05);
        chk("pkt1_data", {16'd0, data}, 32'hA53C);
        chk("pkt1_rdy", {31'd0, cmd_rdy}, 1);

        send_byte(8'h02, 30);
        send_byte(8'h12, 30);
        send_byte(8'h06, BYTE_TO + 200);
        send_byte(8'h00, 30);
        send_byte(8'h01, 30);
        chk("to_cmd", {24'd0, cmd}, 32'h06);
        chk("to_data", {16'd0, data}, 32'h0001);

        clr_pulse();
        send_byte(8'h07, 20);
        send_byte(8'h08, 20);
        fork
            send_byte(8'h09, 20);
            begin
                seen = 1'b0;
                @(posedge clk);
                #1 clr_cmd_rdy = 1'b1;
                for (int i = 0; i < FRAME + 100 && !seen; i++) begin
                    @(posedge clk);
                    #1;
                    if (cmd_rdy) seen = 1'b1;
                end
                chk("set_wins", {31'd0, seen}, 1);
                @(posedge clk);
                #1;
                chk("clr_next", {31'd0, cmd_rdy}, 0);
                clr_cmd_rdy = 1'b0;
            end
        join
        exp_rdy = 1'b0;
        chk("sw_cmd", {24'd0, cmd}, 32'h07);
        chk("sw_data", {16'd0, data}, 32'h0809);

        do_resp(8'hA5, 1'b1);
        repeat (FRAME + 2 * BAUD) @(posedge clk);
        tx_drain();

        fork
            do_resp(8'h5A, 1'b0);
            begin
                send_byte(8'h04, 10);
                send_byte(8'hFF, 10);
                send_byte(8'hFF, 10);
            end
        join
        chk("fd_cmd", {24'd0, cmd}, 32'h04);
        chk("fd_data", {16'd0, data}, 32'hFFFF);
        repeat (BAUD) @(posedge clk);
        tx_drain();

        fork
            begin : rx_rand
                logic [7:0] rb;
                int g;
                for (int k = 0; k < 24; k++) begin
                    g = ($urandom_range(0, 5) == 0) ?
                        LONG + int'($urandom_range(0, 200)) :
                        int'($urandom_range(0, 250));
                    case ($urandom_range(0, 5))
                        0:       rb = 8'h00;
                        1:       rb = 8'hFF;
                        default: rb = 8'($urandom_range(0, 255));
                    endcase
                    send_byte(rb, g);
                    if ($urandom_range(0, 3) == 0) clr_pulse();
                end
            end
            begin : tx_rand
                for (int k = 0; k < 6; k++) begin
                    repeat ($urandom_range(10, 400)) @(posedge clk);
                    do_resp(8'($urandom_range(0, 255)), 1'b0);
                end
            end
        join
        repeat (BAUD) @(posedge clk);
        tx_drain();

        send_byte(8'h11, LONG);
        send_byte(8'h22, 5);
        @(posedge clk);
        #1 resp = 8'h77;
        send_resp = 1'b1;
        @(posedge clk);
        #1 send_resp = 1'b0;
        repeat (4 * BAUD) @(posedge clk);
        #2 rst_n = 1'b0;
        rst_cnt++;
        #1;
        chk("mid_rst_cmd", {24'd0, cmd}, 0);
        chk("mid_rst_data", {16'd0, data}, 0);
        chk("mid_rst_rdy", {31'd0, cmd_rdy}, 0);
        chk("mid_rst_resp_sent", {31'd0, resp_sent}, 0);
        chk("mid_rst_tx", {31'd0, TX}, 1);
        exp_cmd  = 8'h00;
        exp_data = 16'h0000;
        exp_rdy  = 1'b0;
        partial.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send_byte(8'h01, 10);
        send_byte(8'h00, 10);
        send_byte(8'h10, 10);
        chk("post_cmd", {24'd0, cmd}, 32'h01);
        chk("post_data", {16'd0, data}, 32'h0010);
        chk("post_rdy", {31'd0, cmd_rdy}, 1);
        repeat (FRAME) @(posedge clk);
        tx_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
